// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one external memory port between I-side refill and
// D-side refill/write-back; every grant is a fixed-length, line-aligned burst.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no transfer; arbitrate pending requests, latch winner and base
// BURST | issue BEATS memory beats to the winner, one per m_ack
// DONE  | one-cycle done pulse to the winner; pipeline released
module mem_bus_arbiter #(
    parameter int BEATS      = 4,
    parameter int LOG2_BEATS = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_rvalid,
    output logic        i_done,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_wready,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        d_done,

    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,

    output logic        stall
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic                  OWN_I     = 1'b0;
    localparam logic                  OWN_D     = 1'b1;
    localparam logic [LOG2_BEATS-1:0] LAST_BEAT = LOG2_BEATS'(BEATS - 1);
    localparam logic [31:0]           LINE_MASK = ~((32'(BEATS) << 2) - 32'd1);

    state_t                state, state_nxt;
    logic [LOG2_BEATS-1:0] beat, beat_nxt;
    logic                  owner, owner_nxt;
    logic                  last_owner, last_owner_nxt;
    logic                  we_lat, we_lat_nxt;
    logic [31:0]           base, base_nxt;

    logic                  any_req;
    logic                  grant_d;
    logic                  in_burst;
    logic                  in_done;
    logic                  beat_ack;

    // D wins a tie only when I owned the previous burst.
    always_comb begin
        any_req = i_req | d_req;
        grant_d = d_req & (~i_req | (last_owner == OWN_I));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            beat       <= '0;
            owner      <= OWN_I;
            last_owner <= OWN_I;
            we_lat     <= 1'b0;
            base       <= '0;
        end else begin
            state      <= state_nxt;
            beat       <= beat_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            we_lat     <= we_lat_nxt;
            base       <= base_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        beat_nxt       = beat;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        we_lat_nxt     = we_lat;
        base_nxt       = base;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt      = S_BURST;
                    beat_nxt       = '0;
                    owner_nxt      = grant_d ? OWN_D : OWN_I;
                    last_owner_nxt = grant_d ? OWN_D : OWN_I;
                    we_lat_nxt     = grant_d & d_we;
                    base_nxt       = (grant_d ? d_addr : i_addr) & LINE_MASK;
                end
            end
            S_BURST: begin
                // Beat counter wraps to zero on the last ack (BEATS is a power of 2).
                if (m_ack) begin
                    beat_nxt = beat + LOG2_BEATS'(1);
                    if (beat == LAST_BEAT) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_burst = (state == S_BURST);
        in_done  = (state == S_DONE);
        beat_ack = in_burst & m_ack;

        m_req    = in_burst;
        m_we     = in_burst & we_lat;
        m_addr   = in_burst ? (base + 32'({beat, 2'b00})) : 32'd0;
        m_wdata  = in_burst ? d_wdata : 32'd0;

        i_rvalid = beat_ack & (owner == OWN_I);
        d_rvalid = beat_ack & (owner == OWN_D) & ~we_lat;
        d_wready = beat_ack & (owner == OWN_D) & we_lat;
        i_rdata  = in_burst ? m_rdata : 32'd0;
        d_rdata  = in_burst ? m_rdata : 32'd0;

        i_done   = in_done & (owner == OWN_I);
        d_done   = in_done & (owner == OWN_D);

        // Gated by rst_n so the freeze drops the instant reset is asserted.
        stall    = rst_n & (in_burst | ((state == S_IDLE) & any_req));
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a transaction-level model predicts each
// grant (owner, write flag, line base) and a negedge monitor checks every beat.
module tb_mem_bus_arbiter;

    localparam int BEATS      = 4;
    localparam int LOG2_BEATS = 2;

    logic        clk;
    logic        rst_n;
    logic        i_req, d_req, d_we, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_rvalid, i_done, d_wready, d_rvalid, d_done;
    logic        m_req, m_we, stall;

    mem_bus_arbiter #(.BEATS(BEATS), .LOG2_BEATS(LOG2_BEATS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(m_ack),
        .m_rdata(m_rdata), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        owner;   // 0 = I side, 1 = D side
        logic        we;
        logic [31:0] base;
    } xfer_t;

    typedef enum int {PH_IDLE, PH_BUSY, PH_DONE} phase_t;

    xfer_t  exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    phase_t mph     = PH_IDLE;
    logic   mowner  = 1'b0;
    logic   mlast   = 1'b0;
    int     macks   = 0;
    int     ack_mode  = 0;
    int     raise_pct = 100;
    bit     auto_i = 0, auto_d = 0;
    int     mon_beat = 0;
    int     i_done_cnt = 0;
    logic   done_log[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] line_base(logic [31:0] a);
        return (a / (BEATS * 4)) * (BEATS * 4);
    endfunction

    // Transaction view of the arbiter, advanced once per rising edge using the
    // inputs that were present at that edge.
    task automatic model_step();
        logic g;
        if (!rst_n) begin
            mph = PH_IDLE; mlast = 1'b0; mowner = 1'b0; macks = 0;
            exp_q.delete();
            return;
        end
        case (mph)
            PH_IDLE: if (i_req || d_req) begin
                g = (i_req && d_req) ? !mlast : d_req;
                exp_q.push_back('{owner: g, we: g ? d_we : 1'b0, base: line_base(g ? d_addr : i_addr)});
                mlast = g; mowner = g; macks = 0; mph = PH_BUSY;
            end
            PH_BUSY: if (m_ack) begin
                macks++;
                if (macks == BEATS) mph = PH_DONE;
            end
            default: mph = PH_IDLE;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        if (i_done) i_req = 1'b0;
        if (d_done) d_req = 1'b0;
        case (ack_mode)
            0:       m_ack = 1'b1;
            1:       m_ack = !m_ack;
            default: m_ack = ($urandom_range(0, 3) != 0);
        endcase
        m_rdata = $urandom;
        d_wdata = $urandom;
        if (auto_i && !i_req && !i_done && $urandom_range(0, 99) < raise_pct) begin
            i_addr = $urandom; i_req = 1'b1;
        end
        if (auto_d && !d_req && !d_done && $urandom_range(0, 99) < raise_pct) begin
            d_addr = $urandom; d_we = $urandom_range(0, 1) != 0; d_req = 1'b1;
        end
    endtask

    task automatic run_quiet(string name, int budget);
        for (int k = 0; k < budget; k++) begin
            tick();
            if (!i_req && !d_req && mph == PH_IDLE && exp_q.size() == 0) return;
        end
        n_tests++; n_fail++;
        $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, budget);
    endtask

    // Monitor: compares DUT outputs against the scoreboard head on every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_outs", {m_req, stall, i_rvalid, d_rvalid, d_wready, i_done, d_done}, 32'd0);
            chk("rst_m_addr", m_addr, 32'd0);
            mon_beat = 0;
        end else begin
            chk("stall", stall, (mph == PH_BUSY) || (mph == PH_IDLE && (i_req || d_req)));
            chk("m_req", m_req, mph == PH_BUSY);
            chk("done", {i_done, d_done}, {mph == PH_DONE && !mowner, mph == PH_DONE && mowner});
            if (m_req && exp_q.size() > 0) begin
                chk("m_addr", m_addr, exp_q[0].base + 32'(4 * mon_beat));
                chk("m_we", m_we, exp_q[0].we);
                if (exp_q[0].we) chk("m_wdata", m_wdata, d_wdata);
                if (m_ack) begin
                    chk("strobes", {i_rvalid, d_rvalid, d_wready},
                        {!exp_q[0].owner, exp_q[0].owner && !exp_q[0].we, exp_q[0].owner && exp_q[0].we});
                    if (i_rvalid) chk("i_rdata", i_rdata, m_rdata);
                    if (d_rvalid) chk("d_rdata", d_rdata, m_rdata);
                    mon_beat++;
                end else begin
                    chk("strobes_wait", {i_rvalid, d_rvalid, d_wready}, 32'd0);
                end
            end else begin
                chk("strobes_idle", {i_rvalid, d_rvalid, d_wready}, 32'd0);
            end
            if (i_done || d_done) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL done_unexpected: got done pulse, expected no transfer pending");
                end else begin
                    chk("done_owner", d_done, exp_q[0].owner);
                    chk("done_beats", mon_beat, BEATS);
                    void'(exp_q.pop_front());
                end
                mon_beat = 0;
                done_log.push_back(d_done);
                if (i_done) i_done_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int base_cnt;
        int base_log;
        rst_n = 1'b0; i_req = 0; d_req = 0; d_we = 0; m_ack = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // I-only line read, ack every cycle
        ack_mode = 0;
        base_cnt = i_done_cnt;
        i_addr = 32'h0000_104C; i_req = 1'b1;
        run_quiet("i_read", 40);
        chk("i_read_done_cnt", i_done_cnt - base_cnt, 1);

        // D write-back, ack every other cycle
        ack_mode = 1;
        base_log = done_log.size();
        d_addr = 32'h0000_2000; d_we = 1'b1; d_req = 1'b1;
        run_quiet("d_wb", 40);
        chk("d_wb_done_cnt", done_log.size() - base_log, 1);
        d_we = 1'b0;

        // Reset asserted mid-burst at beat 2
        ack_mode = 0;
        i_addr = 32'h0000_3010; i_req = 1'b1;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (mph == PH_BUSY && macks == 2) begin ok = 1; break; end
        end
        chk("rst_reach_beat2", ok, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", {m_req, stall, i_rvalid, i_done, d_done}, 32'd0);
        chk("rst_async_addr", m_addr, 32'd0);
        i_req = 1'b0;
        mph = PH_IDLE; mlast = 1'b0; macks = 0; exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        base_cnt = i_done_cnt;
        i_addr = 32'h0000_3018; i_req = 1'b1;
        run_quiet("post_rst", 40);
        chk("post_rst_done_cnt", i_done_cnt - base_cnt, 1);

        // Simultaneous requests from reset, then continuous re-requesting
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        base_log = done_log.size();
        ack_mode = 2; raise_pct = 100;
        i_addr = 32'h0000_4004; d_addr = 32'h0000_5008; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        auto_i = 1; auto_d = 1;
        for (int k = 0; k < 200 && done_log.size() < base_log + 4; k++) tick();
        auto_i = 0; auto_d = 0;
        run_quiet("rr", 100);
        if (done_log.size() < base_log + 4) begin
            n_tests++; n_fail++;
            $display("FAIL rr_count: got %0d grants, expected at least 4", done_log.size() - base_log);
        end else begin
            chk("rr_order", {done_log[base_log], done_log[base_log+1], done_log[base_log+2], done_log[base_log+3]},
                32'b1010);
        end

        // I drops its request at beat 1; burst still completes
        ack_mode = 0;
        base_cnt = i_done_cnt;
        i_addr = 32'h0000_6000; i_req = 1'b1;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (mph == PH_BUSY && macks == 1) begin ok = 1; break; end
        end
        chk("drop_reach_beat1", ok, 1'b1);
        i_req = 1'b0;
        run_quiet("drop", 40);
        chk("drop_done_cnt", i_done_cnt - base_cnt, 1);

        // Randomized traffic
        ack_mode = 2; raise_pct = 30;
        auto_i = 1; auto_d = 1;
        repeat (2000) tick();
        auto_i = 0; auto_d = 0;
        run_quiet("random", 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
